// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: after reset it zero-fills registers 1..N-1,
// then arbitrates two write ports (A = pipeline writeback, B = long-latency
// unit) onto a single registered register-file write port. A normally wins.
// B is guaranteed a grant after waiting three cycles.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | zero-fill sweep of registers 1..2**ADDRESS_WIDTH-1, no grants
// RUN   | arbitration between ports A and B, init_done high
module rf_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     b_ready,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic                     init_done
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] sweep_q, sweep_d;
    logic [1:0]               starve_q, starve_d;
    logic                     starving;
    logic                     a_xfer, b_xfer;
    logic                     we_d;
    logic [ADDRESS_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_d;

    // B has been kept waiting long enough that it must win this cycle
    assign starving = (starve_q == 2'd3) && b_valid;
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;

    // State register: FSM state, sweep address and B starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_CLEAR;
            sweep_q  <= ADDRESS_WIDTH'(1);
            starve_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic; the sweep counter wraps to 0 after the last
    // register, which is the cue to leave CLEAR
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        starve_d = 2'd0;
        if (state_q == S_CLEAR) begin
            sweep_d = sweep_q + ADDRESS_WIDTH'(1);
            if (sweep_q == '0) begin
                state_d = S_RUN;
                sweep_d = sweep_q;
            end
        end else begin
            if (b_valid && !b_ready) begin
                starve_d = (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;
            end
        end
    end

    // Output logic: grants, init flag and the next register-file write.
    // a_ready is held low whenever B is granted so the grants stay exclusive.
    always_comb begin
        b_ready   = 1'b0;
        a_ready   = 1'b0;
        init_done = 1'b0;
        we_d      = 1'b0;
        waddr_d   = rf_waddr;
        wdata_d   = rf_wdata;
        if (state_q == S_CLEAR) begin
            if (sweep_q != '0) begin
                we_d    = 1'b1;
                waddr_d = sweep_q;
                wdata_d = '0;
            end
        end else begin
            init_done = 1'b1;
            b_ready   = !a_valid || starving;
            a_ready   = !b_ready;
            if (a_xfer) begin
                we_d    = (a_addr != '0);
                waddr_d = a_addr;
                wdata_d = a_data;
            end else if (b_xfer) begin
                we_d    = (b_addr != '0);
                waddr_d = b_addr;
                wdata_d = b_data;
            end
        end
    end

    // Single output register towards the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= we_d;
            rf_waddr <= waddr_d;
            rf_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: reset values, clear sweep, directed vector
// table, reset during sweep and during RUN, randomized traffic vs a model.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          init_done;

    int n_pass  = 0;
    int n_total = 0;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ar;
        logic          br;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic av, input int aa, input logic [DW-1:0] ad,
                                input logic bv, input int ba, input logic [DW-1:0] bd,
                                input logic ar, input logic br,
                                input logic we, input int wa, input logic [DW-1:0] wd);
        vec_t v;
        v.av = av; v.aa = AW'(aa); v.ad = ad;
        v.bv = bv; v.ba = AW'(ba); v.bd = bd;
        v.ar = ar; v.br = br;
        v.we = we; v.wa = AW'(wa); v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called just after a negedge: assert reset away from the clock edge,
    // check outputs clear at once and stay clear while clocking, release.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_rf_waddr",  32'(rf_waddr),  32'd0);
        chk("rst_rf_wdata",  32'(rf_wdata),  32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_a_ready",   32'(a_ready),   32'd0);
        chk("rst_b_ready",   32'(b_ready),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_rf_we",     32'(rf_we),     32'd0);
        chk("rst_hold_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Follows a release at a negedge. Checks sweep writes 1..31; with
    // abort_at > 0 returns right after checking that sweep address.
    // Otherwise ends just after the edge on which init_done must rise.
    task automatic sweep_check(input int abort_at);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk("sweep_we",      32'(rf_we),     32'd1);
            chk("sweep_addr",    32'(rf_waddr),  32'(k));
            chk("sweep_data",    32'(rf_wdata),  32'd0);
            chk("sweep_init",    32'(init_done), 32'd0);
            chk("sweep_a_ready", 32'(a_ready),   32'd0);
            chk("sweep_b_ready", 32'(b_ready),   32'd0);
            if (k == abort_at) return;
        end
        @(posedge clk);
        #1;
    endtask

    // Randomized traffic obeying the hold-until-granted rule, checked
    // against a cycle model: A wins unless idle or B has waited 3+ cycles.
    task automatic random_phase(input int n);
        logic          m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        int            b_wait;
        logic          a_go, b_go, starving, e_ar, e_br;
        m_we = 1'b0; m_addr = '0; m_data = '0;
        b_wait = 0; a_go = 1'b0; b_go = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!a_valid || a_go) begin
                a_valid = ($urandom_range(0, 99) < 70);
                a_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || b_go) begin
                b_valid = ($urandom_range(0, 99) < 50);
                b_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                b_data  = $urandom;
            end
            @(negedge clk);
            starving = b_valid && (b_wait >= 3);
            e_br     = !a_valid || starving;
            e_ar     = !e_br;
            chk("rnd_a_ready",   32'(a_ready),   32'(e_ar));
            chk("rnd_b_ready",   32'(b_ready),   32'(e_br));
            chk("rnd_init_done", 32'(init_done), 32'd1);
            chk("rnd_rf_we",     32'(rf_we),     32'(m_we));
            if (m_we) begin
                chk("rnd_rf_waddr", 32'(rf_waddr), 32'(m_addr));
                chk("rnd_rf_wdata", 32'(rf_wdata), m_data);
            end
            a_go = a_valid && e_ar;
            b_go = b_valid && e_br;
            if (a_go) begin
                m_we = (a_addr != 0); m_addr = a_addr; m_data = a_data;
            end else if (b_go) begin
                m_we = (b_addr != 0); m_addr = b_addr; m_data = b_data;
            end else begin
                m_we = 1'b0;
            end
            if (b_valid && !b_go) b_wait++;
            else b_wait = 0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //              A: v  addr data          B: v  addr data        ar    br    we  waddr wdata
        vecs[0]  = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b0,  0, 32'h0);
        vecs[1]  = mk(1'b1,  5, 32'hDEADBEEF, 1'b0,  0, 32'h0,    1'b1, 1'b0, 1'b0,  0, 32'h0);
        vecs[2]  = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b1,  5, 32'hDEADBEEF);
        vecs[3]  = mk(1'b1,  3, 32'h33,       1'b1,  7, 32'h77,   1'b1, 1'b0, 1'b0,  0, 32'h0);
        vecs[4]  = mk(1'b0,  0, 32'h0,        1'b1,  7, 32'h77,   1'b0, 1'b1, 1'b1,  3, 32'h33);
        vecs[5]  = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b1,  7, 32'h77);
        vecs[6]  = mk(1'b1,  0, 32'h1234,     1'b0,  0, 32'h0,    1'b1, 1'b0, 1'b0,  0, 32'h0);
        vecs[7]  = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b0,  0, 32'h0);
        vecs[8]  = mk(1'b1, 10, 32'hA0,       1'b1,  9, 32'h99,   1'b1, 1'b0, 1'b0,  0, 32'h0);
        vecs[9]  = mk(1'b1, 11, 32'hB0,       1'b1,  9, 32'h99,   1'b1, 1'b0, 1'b1, 10, 32'hA0);
        vecs[10] = mk(1'b1, 12, 32'hC0,       1'b1,  9, 32'h99,   1'b1, 1'b0, 1'b1, 11, 32'hB0);
        vecs[11] = mk(1'b1, 13, 32'hD0,       1'b1,  9, 32'h99,   1'b0, 1'b1, 1'b1, 12, 32'hC0);
        vecs[12] = mk(1'b1, 13, 32'hD0,       1'b0,  0, 32'h0,    1'b1, 1'b0, 1'b1,  9, 32'h99);
        vecs[13] = mk(1'b1, 14, 32'hE0,       1'b0,  0, 32'h0,    1'b1, 1'b0, 1'b1, 13, 32'hD0);
        vecs[14] = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b1, 14, 32'hE0);
        vecs[15] = mk(1'b1, 15, 32'hF0,       1'b1, 20, 32'h2020, 1'b1, 1'b0, 1'b0,  0, 32'h0);
        vecs[16] = mk(1'b1, 16, 32'hF1,       1'b1, 20, 32'h2020, 1'b1, 1'b0, 1'b1, 15, 32'hF0);
        vecs[17] = mk(1'b0,  0, 32'h0,        1'b1, 20, 32'h2020, 1'b0, 1'b1, 1'b1, 16, 32'hF1);
        vecs[18] = mk(1'b0,  0, 32'h0,        1'b0,  0, 32'h0,    1'b0, 1'b1, 1'b1, 20, 32'h2020);

        // Power-on reset, then a full sweep with no requests
        apply_reset();
        sweep_check(0);

        // Directed table, first row is the first RUN cycle
        for (int i = 0; i < 19; i++) begin
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            @(negedge clk);
            chk($sformatf("vec%0d_a_ready", i),   32'(a_ready),   32'(vecs[i].ar));
            chk($sformatf("vec%0d_b_ready", i),   32'(b_ready),   32'(vecs[i].br));
            chk($sformatf("vec%0d_init_done", i), 32'(init_done), 32'd1);
            chk($sformatf("vec%0d_rf_we", i),     32'(rf_we),     32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].wa));
                chk($sformatf("vec%0d_rf_wdata", i), 32'(rf_wdata), vecs[i].wd);
            end
            @(posedge clk);
            #1;
        end

        // Reset pulsed at sweep address 10 with requests pending throughout
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        apply_reset();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
        sweep_check(10);
        apply_reset();
        sweep_check(0);

        random_phase(1500);

        // Reset in the middle of RUN with both requests pending
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        apply_reset();
        sweep_check(0);
        random_phase(1500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width (2**ADDRESS_WIDTH registers).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as follows: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a_valid  input  1  port A (pipeline writeback) write request.
REQ-006 a_addr  input  ADDRESS_WIDTH  port A destination register.
REQ-007 a_data  input  DATA_WIDTH  port A write data.
REQ-008 a_ready  output  1  port A grant; a transfer occurs when a_valid and a_ready are both high.
REQ-009 b_valid, b_addr, b_data, b_ready  same widths and meanings as port A, for port B (multi-cycle load/long-latency unit).
REQ-010 rf_we  output  1  register-file write enable (registered).
REQ-011 rf_waddr  output  ADDRESS_WIDTH  register-file write address (registered).
REQ-012 rf_wdata  output  DATA_WIDTH  register-file write data (registered).
REQ-013 init_done  output  1  high once the post-reset clear sweep has finished.

Function
REQ-014 SHALL implement two states: CLEAR (zero-fill sweep) and RUN (arbitration).
REQ-015 CLEAR: sweep counter starts at 1; each cycle, drive a write of 0 to the counter address, then increment; leave CLEAR for RUN in the cycle after address 2**ADDRESS_WIDTH-1 is issued (31 sweep writes at default width; address 0 is never written).
REQ-016 In CLEAR, a_ready and b_ready SHALL be 0 and init_done SHALL be 0; init_done SHALL be 1 in every RUN cycle.
REQ-017 a_ready and b_ready SHALL be combinational functions of state, a_valid and the starvation counter; at most one of them is high per cycle.
REQ-018 RUN default priority: a_ready = 1 unless the starvation condition holds; b_ready = 1 when a_valid = 0 or the starvation condition holds.
REQ-019 Starvation counter: 2-bit; increments (saturating at 3) each RUN cycle with b_valid = 1 and b_ready = 0; clears to 0 on a B transfer or when b_valid = 0.
REQ-020 Starvation condition: counter = 3 and b_valid = 1; port B then wins, so B waits at most 3 cycles under continuous A traffic.
REQ-021 Requesters SHALL hold valid, addr and data stable until the transfer; the block need not tolerate a request withdrawn before its grant.
REQ-022 Latency: a transfer in cycle N produces rf_we = 1 with that transfer's addr and data in cycle N+1; no transfer in cycle N produces rf_we = 0 in cycle N+1.
REQ-023 A transfer with address 0 SHALL complete the handshake but produce rf_we = 0 in cycle N+1.
REQ-024 No write data SHALL be modified, merged or buffered beyond the single output register; throughput is one write per cycle.
REQ-025 Same-address simultaneous requests carry no special rule; ordering follows arbitration (REQ-018 to REQ-020).

Reset
REQ-026 While rst_n = 0, regardless of clk: state = CLEAR, sweep counter = 1, starvation counter = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, init_done = 0, a_ready = 0, b_ready = 0.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL abort all activity and restart the full sweep from address 1 after release.
REQ-028 A request pending at reset assertion is not granted; the requester re-presents it after init_done rises.

Verification
REQ-029 Reset release, no requests -> rf_we = 1 for 31 consecutive cycles, rf_waddr 1..31, rf_wdata 0; init_done rises the next cycle.
REQ-030 After init, A valid addr 5 data 0xDEADBEEF -> a_ready = 1 same cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
REQ-031 A and B both valid in one cycle (A addr 3, B addr 7) -> A granted; B granted the next cycle once A drops; rf writes 3 then 7.
REQ-032 A valid every cycle, B valid continuously -> B granted in the 4th cycle of waiting, A stalled that cycle; counter returns to 0.
REQ-033 A valid addr 0 data 0x1234 -> a_ready = 1, rf_we stays 0 the next cycle.
REQ-034 rst_n pulsed low at sweep address 10 -> outputs go to 0 immediately; after release, the sweep restarts at address 1 and init_done rises 32 cycles later.
